// File: rtl/dispatch_sequencer.sv
// Address/credit sequencer feeding the dispatcher ROM stage: walks a contiguous ROM window and
// advances by however many words the ROM actually placed on free output lanes each cycle.
module dispatch_sequencer #(
  parameter int unsigned LogRomSize  = 5,
  parameter int unsigned LogOutPorts = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [LogRomSize-1:0]         base_addr_i,
  input  logic [LogRomSize:0]           length_i,
  input  logic [(1<<LogOutPorts)-1:0]   stall_word_i,
  output logic                          read_o,
  output logic [LogRomSize-1:0]         addr_o,
  output logic [LogOutPorts:0]          n_v_out_o,
  output logic [LogOutPorts:0]          issued_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned NumLanes = 1 << LogOutPorts;
  localparam int unsigned CntW     = LogOutPorts + 1;
  localparam int unsigned RemW     = LogRomSize + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [LogRomSize-1:0] addr_q, addr_d;
  logic [RemW-1:0]       rem_q, rem_d;

  logic [CntW-1:0] n_v;
  logic [CntW-1:0] free;
  logic [CntW-1:0] issued;
  logic [RemW-1:0] rem_next;

  // Credit the ROM may use this cycle, and what it actually used given busy lanes.
  always_comb begin
    n_v = '0;
    if (state_q == StRun) begin
      n_v = (rem_q >= RemW'(NumLanes)) ? CntW'(NumLanes) : CntW'(rem_q);
    end
    free = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      free = free + CntW'(!stall_word_i[i]);
    end
    issued   = (free < n_v) ? free : n_v;
    rem_next = rem_q - RemW'(issued);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = length_i;
          state_d = (length_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          // Cancel keeps the address where it stopped but drops the remaining credit.
          rem_d   = '0;
          state_d = StIdle;
        end else begin
          addr_d = addr_q + LogRomSize'(issued);
          rem_d  = rem_next;
          if (rem_next == '0) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign read_o    = (state_q == StRun);
  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign addr_o    = addr_q;
  assign n_v_out_o = n_v;
  assign issued_o  = issued;

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Scoreboard bench for dispatch_sequencer (N=8, depth 32): directed walks push hand-computed
// per-cycle expectations; a negedge monitor pops one entry whenever read or done is seen.
module tb_dispatch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic [4:0] base_addr_i;
  logic [5:0] length_i;
  logic [7:0] stall_word_i;
  logic       read_o;
  logic [4:0] addr_o;
  logic [3:0] n_v_out_o;
  logic [3:0] issued_o;
  logic       busy_o;
  logic       done_o;

  dispatch_sequencer #(
    .LogRomSize (5),
    .LogOutPorts(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .stall_word_i(stall_word_i),
    .read_o      (read_o),
    .addr_o      (addr_o),
    .n_v_out_o   (n_v_out_o),
    .issued_o    (issued_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int addr;
    int nv;
    int iss;
  } exp_t;

  typedef logic [7:0] stall_q_t[$];

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_run(input int a, input int nv, input int iss);
    exp_q.push_back('{is_done: 1'b0, addr: a, nv: nv, iss: iss});
  endtask

  task automatic push_done();
    exp_q.push_back('{is_done: 1'b1, addr: 0, nv: 0, iss: 0});
  endtask

  // Monitor: every visible RUN or DONE cycle must match the next expected entry.
  always @(negedge clk) begin
    if (busy_o) busy_cnt++;
    if (rst_n && (read_o || done_o)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got read=%0b done=%0b required none (t=%0t)",
                 read_o, done_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("done", 32'(done_o), 32'(mon_e.is_done));
        check("read", 32'(read_o), 32'(!mon_e.is_done));
        check("busy", 32'(busy_o), 32'(!mon_e.is_done));
        if (!mon_e.is_done) begin
          check("addr", 32'(addr_o), mon_e.addr);
          check("n_v_out", 32'(n_v_out_o), mon_e.nv);
          check("issued", 32'(issued_o), mon_e.iss);
        end
      end
    end
  end

  // Start a walk, then apply one stall word per following cycle; optional abort / stray start.
  task automatic walk(input int base, input int len, input stall_q_t stalls,
                      input int abort_at, input int poke_at);
    int t;
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = 5'(base);
    length_i    = 6'(len);
    for (int i = 0; i < stalls.size(); i++) begin
      @(posedge clk); #1;
      start_i      = 1'b0;
      abort_i      = (i == abort_at);
      stall_word_i = stalls[i];
      if (i == poke_at) begin
        start_i     = 1'b1;
        base_addr_i = 5'd31;
        length_i    = 6'd3;
      end
    end
    @(posedge clk); #1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    stall_word_i = 8'h00;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    base_addr_i  = '0;
    length_i     = '0;
    stall_word_i = '0;
    #3;
    check("reset_outputs", 32'({read_o, addr_o, n_v_out_o, issued_o, busy_o, done_o}), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // No stalls: two RUN cycles, busy exactly 2.
    push_run(4, 8, 8);
    push_run(12, 2, 2);
    push_done();
    busy_cnt = 0;
    walk(4, 10, '{8'h00, 8'h00}, -1, -1);
    check("nostall_busy_cycles", busy_cnt, 2);
    check("nostall_end_addr", 32'(addr_o), 14);

    // Upper four lanes busy.
    push_run(0, 8, 4);
    push_run(4, 6, 4);
    push_run(8, 2, 2);
    push_done();
    walk(0, 10, '{8'hF0, 8'hF0, 8'hF0}, -1, -1);
    check("partial_end_addr", 32'(addr_o), 10);

    // All lanes busy for three cycles mid-walk.
    push_run(0, 8, 8);
    push_run(8, 4, 0);
    push_run(8, 4, 0);
    push_run(8, 4, 0);
    push_run(8, 4, 4);
    push_done();
    walk(0, 12, '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00}, -1, -1);
    check("fullstall_end_addr", 32'(addr_o), 12);

    // Zero length: done only, never read.
    push_done();
    walk(9, 0, '{}, -1, -1);
    check("zero_len_addr", 32'(addr_o), 9);
    check("zero_len_idle", 32'({busy_o, done_o}), 0);

    // Stray start during RUN is ignored.
    push_run(2, 8, 4);
    push_run(6, 8, 4);
    push_run(10, 8, 4);
    push_run(14, 8, 4);
    push_run(18, 4, 4);
    push_done();
    walk(2, 20, '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0}, -1, 1);
    check("ignored_start_addr", 32'(addr_o), 22);

    // Walk ending exactly at the top wraps to address 0.
    push_run(24, 8, 8);
    push_done();
    walk(24, 8, '{8'h00}, -1, -1);
    check("wrap_addr", 32'(addr_o), 0);

    // Abort in the second RUN cycle: no done, address holds, credit cleared.
    push_run(0, 8, 8);
    push_run(8, 8, 8);
    walk(0, 20, '{8'h00, 8'h00}, 1, -1);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_addr", 32'(addr_o), 8);
    check("abort_rem", 32'(dut.rem_q), 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted during RUN.
    push_run(4, 8, 8);
    @(posedge clk); #1;
    start_i      = 1'b1;
    base_addr_i  = 5'd4;
    length_i     = 6'd20;
    stall_word_i = 8'h00;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", 32'({read_o, addr_o, n_v_out_o, issued_o, busy_o, done_o}), 0);
    #10 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_mid_idle", 32'({busy_o, done_o, read_o}), 0);
    check("reset_mid_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
